// File: rtl/mtx_mem_pkg.sv
// mtx_mem_pkg: shared types and constants for the SRAM-to-SDRAM bridge
package mtx_mem_pkg;
  localparam int DEF_ADDR_W = 23;
  localparam logic [7:0] SRAM_IDLE_Q = 8'hFF;
  typedef enum logic [1:0] {IDLE, DL_WR, CPU_WR, CPU_RD} bridge_state_t;
endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: multi-flop synchronizer for active-low strobes, resets to all-ones (inactive)
module strobe_sync #(
  parameter int WIDTH = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sync_q [STAGES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/sram_sdram_bridge.sv
// sram_sdram_bridge: turns CPU SRAM-bus strobes and ROM-download bytes into
// arbitrated one-shot SDRAM requests with an ack timeout.
module sram_sdram_bridge
  import mtx_mem_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W = mtx_mem_pkg::DEF_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              sram_ce_n,
  input  logic              sram_oe_n,
  input  logic              sram_we_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_d,
  output logic [7:0]        sram_q,
  output logic              sram_rdy,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_rd,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  input  logic              ram_ack,
  output logic              dl_overrun,
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [2:0] strb_s;
  logic ce_s, oe_s, we_s;
  logic cpu_req, dl_take, cpu_take, timed_out, cpu_done;
  bridge_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic armed_q, pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [7:0] pend_data_q;
  strobe_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk_sys),
    .rst_n(reset_n),
    .d_i  ({sram_ce_n, sram_oe_n, sram_we_n}),
    .q_o  (strb_s)
  );
  assign ce_s = strb_s[2];
  assign oe_s = strb_s[1];
  assign we_s = strb_s[0];
  // armed_q makes each CPU strobe produce exactly one SDRAM access
  assign cpu_req   = armed_q & ~ce_s & (~oe_s | ~we_s);
  assign dl_take   = (state_q == IDLE) & pend_q;
  assign cpu_take  = (state_q == IDLE) & ~pend_q & ~ioctl_download & cpu_req;
  assign timed_out = (state_q != IDLE) & ~ram_ack & (cnt_q == CW'(TIMEOUT - 1));
  assign cpu_done  = ((state_q == CPU_WR) | (state_q == CPU_RD)) & (ram_ack | timed_out);
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      sram_q      <= SRAM_IDLE_Q;
      sram_rdy    <= 1'b1;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_rd      <= 1'b0;
      ram_we      <= 1'b0;
      dl_overrun  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (ioctl_wr) begin
        pend_addr_q <= ioctl_addr;
        pend_data_q <= ioctl_data;
      end
      pend_q <= ioctl_wr | (pend_q & ~dl_take);
      if (ioctl_wr & pend_q & ~dl_take) dl_overrun <= 1'b1;
      armed_q  <= cpu_take ? 1'b0 : (ce_s | (oe_s & we_s)) ? 1'b1 : armed_q;
      sram_rdy <= cpu_req ? 1'b0 : cpu_done ? 1'b1 : sram_rdy;
      if (state_q == IDLE) begin
        if (dl_take) begin
          state_q  <= DL_WR;
          ram_we   <= 1'b1;
          ram_addr <= pend_addr_q;
          ram_din  <= pend_data_q;
          cnt_q    <= '0;
        end else if (cpu_take) begin
          state_q  <= we_s ? CPU_RD : CPU_WR;
          ram_we   <= ~we_s;
          ram_rd   <= we_s;
          ram_addr <= sram_addr;
          ram_din  <= sram_d;
          cnt_q    <= '0;
        end
      end else if (ram_ack | timed_out) begin
        state_q <= IDLE;
        ram_rd  <= 1'b0;
        ram_we  <= 1'b0;
        if (state_q == CPU_RD) sram_q <= ram_ack ? ram_dout : SRAM_IDLE_Q;
        if (timed_out) timeout_err <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sram_sdram_bridge.sv
// tb_sram_sdram_bridge: randomized bench with an SDRAM responder, transaction log and memory model
module tb_sram_sdram_bridge;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic sram_ce_n = 1'b1, sram_oe_n = 1'b1, sram_we_n = 1'b1;
  logic [22:0] sram_addr = '0;
  logic [7:0] sram_d = '0;
  logic [7:0] sram_q;
  logic sram_rdy;
  logic ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = '0;
  logic [22:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic ram_rd, ram_we, ram_ack;
  logic dl_overrun, timeout_err;
  typedef struct packed {logic we; logic [22:0] a; logic [7:0] d;} txn_t;
  txn_t log_q[$];
  logic [7:0] sdram [logic [22:0]];
  logic [7:0] model [logic [22:0]];
  int tests = 0, fails = 0;
  int ack_delay = 3, rd_rises = 0, we_rises = 0, rd_high = 0;
  bit ack_en = 1'b1, stray_ack = 1'b0;
  logic prev_rd = 1'b0, prev_we = 1'b0;

  sram_sdram_bridge dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q), .sram_rdy(sram_rdy),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_rd(ram_rd), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_ack(ram_ack),
    .dl_overrun(dl_overrun), .timeout_err(timeout_err)
  );

  always #20 clk_sys = ~clk_sys;

  function automatic logic [7:0] init_byte(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] model_rd(input logic [22:0] a);
    return model.exists(a) ? model[a] : init_byte(a);
  endfunction

  // SDRAM responder: acks each request ack_delay cycles after it appears
  initial begin
    int rcnt;
    rcnt = 0;
    ram_ack = 1'b0;
    ram_dout = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      if (ram_ack || !(ram_rd || ram_we)) begin
        ram_ack = stray_ack;
        rcnt = 0;
      end else begin
        rcnt++;
        if (ack_en && rcnt >= ack_delay) begin
          ram_ack = 1'b1;
          if (ram_we) sdram[ram_addr] = ram_din;
          else ram_dout = sdram.exists(ram_addr) ? sdram[ram_addr] : init_byte(ram_addr);
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (ram_ack && (ram_rd || ram_we)) log_q.push_back({ram_we, ram_addr, ram_we ? ram_din : ram_dout});
    if (ram_rd && !prev_rd) rd_rises++;
    if (ram_we && !prev_we) we_rises++;
    if (ram_rd) rd_high++;
    prev_rd = ram_rd;
    prev_we = ram_we;
  end

  task automatic cpu_op(input logic wr, input logic both, input logic [22:0] a, input logic [7:0] d,
                        input int hold, output logic [7:0] q, output bit ok);
    bit saw_low;
    int n;
    saw_low = 1'b0;
    n = 0;
    sram_addr = a;
    sram_d = d;
    sram_ce_n = 1'b0;
    sram_we_n = ~wr;
    sram_oe_n = wr ? ~both : 1'b0;
    repeat (hold) begin
      @(posedge clk_sys); #1;
      if (!sram_rdy) saw_low = 1'b1;
    end
    while ((!saw_low || !sram_rdy) && n < 600) begin
      @(posedge clk_sys); #1;
      if (!sram_rdy) saw_low = 1'b1;
      n++;
    end
    q = sram_q;
    ok = saw_low && sram_rdy;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_pulse(input logic [22:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({sram_q, sram_rdy, ram_rd, ram_we, ram_addr, ram_din, dl_overrun, timeout_err} !==
        {8'hFF, 1'b1, 1'b0, 1'b0, 23'h0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: q=%h rdy=%b rd=%b we=%b addr=%h din=%h ovr=%b to=%b expected q=ff rdy=1 rest 0",
               sram_q, sram_rdy, ram_rd, ram_we, ram_addr, ram_din, dl_overrun, timeout_err);
    end
  endtask

  task automatic test_cpu_read();
    logic [7:0] q;
    bit ok;
    int r0, l0;
    r0 = rd_rises;
    l0 = log_q.size();
    sdram[23'h012345] = 8'hA5;
    model[23'h012345] = 8'hA5;
    ack_delay = 3;
    cpu_op(1'b0, 1'b0, 23'h012345, 8'h00, 8, q, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL cpu_read_rdy: rdy low/high handshake not seen"); end
    tests++;
    if (q !== 8'hA5) begin fails++; $display("FAIL cpu_read_q: got %h expected a5", q); end
    tests++;
    if (rd_rises - r0 !== 1) begin fails++; $display("FAIL cpu_read_once: %0d ram_rd pulses expected 1", rd_rises - r0); end
    tests++;
    if (log_q.size() != l0 + 1 || log_q[log_q.size()-1] !== {1'b0, 23'h012345, 8'hA5}) begin
      fails++; $display("FAIL cpu_read_txn: log size %0d expected %0d", log_q.size(), l0 + 1);
    end
  endtask

  task automatic test_cpu_write();
    logic [7:0] q;
    bit ok;
    int r0, l0;
    r0 = rd_rises;
    l0 = log_q.size();
    cpu_op(1'b1, 1'b1, 23'h054321, 8'h3C, 3, q, ok);
    model[23'h054321] = 8'h3C;
    tests++;
    if (!ok) begin fails++; $display("FAIL cpu_write_rdy: rdy handshake not seen"); end
    tests++;
    if (rd_rises != r0) begin fails++; $display("FAIL cpu_write_no_rd: %0d ram_rd pulses expected 0", rd_rises - r0); end
    tests++;
    if (log_q.size() != l0 + 1 || log_q[log_q.size()-1] !== {1'b1, 23'h054321, 8'h3C}) begin
      fails++; $display("FAIL cpu_write_txn: log size %0d expected %0d", log_q.size(), l0 + 1);
    end
  endtask

  task automatic test_download();
    logic [7:0] b [3];
    int l0;
    ioctl_download = 1'b1;
    ack_delay = 2;
    l0 = log_q.size();
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      dl_pulse(23'(i), b[i]);
      model[23'(i)] = b[i];
      repeat (5) @(posedge clk_sys);
      #1;
    end
    repeat (10) @(posedge clk_sys);
    #1;
    tests++;
    if (log_q.size() != l0 + 3) begin
      fails++; $display("FAIL dl_count: %0d writes expected 3", log_q.size() - l0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (log_q[l0+i] !== {1'b1, 23'(i), b[i]}) begin
          fails++; $display("FAIL dl_txn%0d: got %h expected %h", i, log_q[l0+i], {1'b1, 23'(i), b[i]});
        end
      end
    end
    tests++;
    if (dl_overrun !== 1'b0) begin fails++; $display("FAIL dl_no_overrun: dl_overrun=%b expected 0", dl_overrun); end
    // back-to-back bytes: byte0 is taken at once, byte1 is overwritten by byte2
    ack_delay = 5;
    l0 = log_q.size();
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      dl_pulse(23'(i), b[i]);
    end
    model[23'd0] = b[0];
    model[23'd2] = b[2];
    repeat (25) @(posedge clk_sys);
    #1;
    tests++;
    if (dl_overrun !== 1'b1) begin fails++; $display("FAIL dl_overrun: dl_overrun=%b expected 1", dl_overrun); end
    tests++;
    if (log_q.size() != l0 + 2 || log_q[l0] !== {1'b1, 23'd0, b[0]} || log_q[l0+1] !== {1'b1, 23'd2, b[2]}) begin
      fails++; $display("FAIL dl_overrun_txn: %0d writes, expected byte0 then byte2", log_q.size() - l0);
    end
  endtask

  task automatic test_collision();
    logic [22:0] ra;
    logic [7:0] dd;
    int r0, l0, n;
    bit early;
    ra = 23'h400000 | 23'($urandom_range(0, 255));
    dd = 8'($urandom);
    ack_delay = 3;
    ioctl_download = 1'b1;
    r0 = rd_rises;
    l0 = log_q.size();
    sram_addr = ra;
    sram_ce_n = 1'b0;
    sram_oe_n = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    tests++;
    if (sram_rdy !== 1'b0 || rd_rises != r0) begin
      fails++; $display("FAIL coll_held: rdy=%b rd_pulses=%0d expected rdy=0 and no read during download", sram_rdy, rd_rises - r0);
    end
    dl_pulse(23'h000100, dd);
    ioctl_download = 1'b0;
    model[23'h000100] = dd;
    n = 0;
    early = 1'b0;
    while (!sram_rdy && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (log_q.size() != l0 + 2) early = 1'b1;
    tests++;
    if (!sram_rdy || early) begin
      fails++; $display("FAIL coll_rdy: rdy=%b txns=%0d when rdy rose, expected 2", sram_rdy, log_q.size() - l0);
    end
    tests++;
    if (log_q.size() < l0 + 2 || log_q[l0] !== {1'b1, 23'h000100, dd} || log_q[l0+1] !== {1'b0, ra, model_rd(ra)}) begin
      fails++; $display("FAIL coll_order: expected download write then CPU read at %h", ra);
    end
    tests++;
    if (sram_q !== model_rd(ra)) begin fails++; $display("FAIL coll_q: got %h expected %h", sram_q, model_rd(ra)); end
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_random();
    logic wr, both;
    logic [22:0] a;
    logic [7:0] d, q, exp_d;
    bit ok;
    int l0;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      both = 1'($urandom_range(0, 1));
      a = 23'h400000 | 23'($urandom_range(0, 7));
      d = 8'($urandom);
      ack_delay = $urandom_range(1, 6);
      exp_d = wr ? d : model_rd(a);
      l0 = log_q.size();
      cpu_op(wr, both, a, d, $urandom_range(0, 5), q, ok);
      if (wr) model[a] = d;
      tests++;
      if (!ok || log_q.size() != l0 + 1 || log_q[log_q.size()-1] !== {wr, a, exp_d}) begin
        fails++; $display("FAIL rand_txn%0d: ok=%b txns=%0d expected one %s at %h data %h", i, ok, log_q.size() - l0, wr ? "write" : "read", a, exp_d);
      end
      if (!wr) begin
        tests++;
        if (q !== exp_d) begin fails++; $display("FAIL rand_q%0d: got %h expected %h", i, q, exp_d); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] q;
    bit ok;
    int h0, l0;
    ack_en = 1'b0;
    h0 = rd_high;
    l0 = log_q.size();
    cpu_op(1'b0, 1'b0, 23'h400003, 8'h00, 0, q, ok);
    tests++;
    if (rd_high - h0 != 255) begin fails++; $display("FAIL to_len: ram_rd high %0d cycles expected 255", rd_high - h0); end
    tests++;
    if (!ok || q !== 8'hFF || timeout_err !== 1'b1 || log_q.size() != l0) begin
      fails++; $display("FAIL to_result: ok=%b q=%h timeout_err=%b expected ok q=ff err=1", ok, q, timeout_err);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] q;
    bit ok;
    int n;
    ack_en = 1'b0;
    sram_addr = 23'h400005;
    sram_d = 8'h77;
    sram_ce_n = 1'b0;
    sram_we_n = 1'b0;
    n = 0;
    while (!ram_we && n < 20) begin
      @(posedge clk_sys); #1;
      n++;
    end
    tests++;
    if (!ram_we) begin fails++; $display("FAIL rst_mid_start: ram_we=%b expected 1", ram_we); end
    #5;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({ram_we, ram_rd, sram_rdy, sram_q, ram_addr, ram_din, dl_overrun, timeout_err} !==
        {1'b0, 1'b0, 1'b1, 8'hFF, 23'h0, 8'h00, 1'b0, 1'b0}) begin
      fails++; $display("FAIL rst_mid_async: we=%b rd=%b rdy=%b q=%h addr=%h din=%h ovr=%b to=%b expected reset values",
                        ram_we, ram_rd, sram_rdy, sram_q, ram_addr, ram_din, dl_overrun, timeout_err);
    end
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b1;
    stray_ack = 1'b1;
    repeat (2) @(posedge clk_sys);
    #2;
    stray_ack = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    tests++;
    if ({ram_we, ram_rd, sram_rdy, sram_q, ram_addr} !== {1'b0, 1'b0, 1'b1, 8'hFF, 23'h0}) begin
      fails++; $display("FAIL rst_idle_ack: we=%b rd=%b rdy=%b q=%h addr=%h expected idle reset values", ram_we, ram_rd, sram_rdy, sram_q, ram_addr);
    end
    ack_en = 1'b1;
    ack_delay = 2;
    cpu_op(1'b0, 1'b0, 23'h012345, 8'h00, 0, q, ok);
    tests++;
    if (!ok || q !== model_rd(23'h012345)) begin
      fails++; $display("FAIL rst_recover: ok=%b q=%h expected %h", ok, q, model_rd(23'h012345));
    end
  endtask

  initial begin
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_download();
    test_collision();
    test_random();
    test_timeout();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
